// File: rtl/dpram_fifo_pkg.sv
// Shared constants and types for the dual-port-RAM FIFO controller.
package dpram_fifo_pkg;
    localparam int DPRAM_AW   = 5;
    localparam int DPRAM_DW   = 8;
    localparam int OBUF_DEPTH = 2;

    typedef logic [DPRAM_AW:0] ptr_t;
    typedef logic [DPRAM_AW:0] cnt_t;
endpackage

// File: rtl/dpram_fifo_ctrl_if.sv
// Upstream/downstream valid-ready stream pair of the FIFO controller.
interface dpram_fifo_ctrl_if import dpram_fifo_pkg::*; #(parameter int DW = DPRAM_DW);
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;

    modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_data);
    modport slave  (input s_valid, s_data, m_ready, output s_ready, m_valid, m_data);
endinterface

// File: rtl/dpram_fifo_obuf.sv
// Two-entry in-order skid buffer that hides the RAM read latency.
module dpram_fifo_obuf import dpram_fifo_pkg::*; #(
    parameter int DW = DPRAM_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          m_ready,
    output logic          pop,
    output logic [1:0]    occ,
    output logic          m_valid,
    output logic [DW-1:0] m_data
);
    logic [DW-1:0] mem [OBUF_DEPTH];
    logic          wsel, rsel;

    assign m_valid = (occ != 2'd0);
    assign pop     = m_valid & m_ready;
    assign m_data  = mem[rsel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wsel <= 1'b0;
            rsel <= 1'b0;
            occ  <= 2'd0;
        end else begin
            if (load) wsel <= ~wsel;
            if (pop)  rsel <= ~rsel;
            occ <= occ + {1'b0, load} - {1'b0, pop};
        end
    end

    // Data storage needs no reset; occ gates visibility.
    always_ff @(posedge clk) begin
        if (load) mem[wsel] <= load_data;
    end
endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller owning both DualPortRam ports, with prefetch into a skid buffer.
// Optional registered almost_full output via DPRAM_FIFO_ALMOST_FULL_EN.
module dpram_fifo_ctrl import dpram_fifo_pkg::*; #(
    parameter int n1 = DPRAM_AW,
    parameter int n2 = DPRAM_DW
`ifdef DPRAM_FIFO_ALMOST_FULL_EN
  , parameter int AF_LEVEL = 28
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    dpram_fifo_ctrl_if.slave bus,
    output logic          ram_we,
    output logic [n1-1:0] ram_wadr,
    output logic [n2-1:0] ram_wdata,
    output logic          ram_re,
    output logic [n1-1:0] ram_radr,
    input  logic [n2-1:0] ram_rdata,
    output logic [n1:0]   count,
    output logic          full,
    output logic          empty
`ifdef DPRAM_FIFO_ALMOST_FULL_EN
  , output logic          almost_full
`endif
);
    logic [n1:0] wptr, rptr, count_next;
    logic        rd_pend, push, pop, issue, ram_avail;
    logic [1:0]  occ;
    logic [2:0]  inflight;

    assign full      = (wptr[n1] != rptr[n1]) && (wptr[n1-1:0] == rptr[n1-1:0]);
    assign bus.s_ready = !full;
    assign push      = bus.s_valid & !full;

    assign ram_we    = push;
    assign ram_wadr  = wptr[n1-1:0];
    assign ram_wdata = bus.s_data;

    // Registered pointers: a word written this cycle is not readable until the next.
    assign ram_avail = (wptr != rptr);
    assign inflight  = {1'b0, occ} + {2'b0, rd_pend} - {2'b0, pop};
    assign issue     = ram_avail && (inflight < 3'd2);
    assign ram_re    = issue;
    assign ram_radr  = rptr[n1-1:0];

    assign count_next = count + (n1+1)'(push) - (n1+1)'(pop);
    assign empty      = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            rd_pend <= 1'b0;
            count   <= '0;
        end else begin
            if (push)  wptr <= wptr + (n1+1)'(1);
            if (issue) rptr <= rptr + (n1+1)'(1);
            rd_pend <= issue;
            count   <= count_next;
        end
    end

`ifdef DPRAM_FIFO_ALMOST_FULL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) almost_full <= 1'b0;
        else        almost_full <= (count_next >= (n1+1)'(AF_LEVEL));
    end
`endif

    dpram_fifo_obuf #(.DW(n2)) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (rd_pend),
        .load_data (ram_rdata),
        .m_ready   (bus.m_ready),
        .pop       (pop),
        .occ       (occ),
        .m_valid   (bus.m_valid),
        .m_data    (bus.m_data)
    );
endmodule

// File: doc/dpram_fifo_ctrl.md
Name: dpram_fifo_ctrl

Overview:
- FIFO controller that sits directly upstream of the DualPortRam and owns its write and read ports (we, write, WAdr, re, RAdr, read).
- Turns the RAM into a 2^n1-deep FIFO with valid/ready handshakes on both sides.
- Prefetches RAM data into a 2-entry output buffer, so one word per cycle streams despite the RAM's 1-cycle read latency and tri-stated read bus.

Parameters:
- n1, 5: address width; RAM depth = 2^n1 = 32.
- n2, 8: data width.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- s_valid, input, 1: upstream word available.
- s_ready, output, 1: controller accepts the word; push = s_valid & s_ready.
- s_data, input, n2: upstream word.
- m_valid, output, 1: output word available.
- m_ready, input, 1: downstream accepts; pop = m_valid & m_ready.
- m_data, output, n2: head-of-FIFO word.
- ram_we, output, 1: to RAM we.
- ram_wadr, output, n1: to RAM WAdr.
- ram_wdata, output, n2: to RAM write.
- ram_re, output, 1: to RAM re.
- ram_radr, output, n1: to RAM RAdr.
- ram_rdata, input, n2: from RAM read; Z when re=0.
- count, output, n1+1: total words held (RAM + in-flight read + output buffer).
- full, output, 1: RAM region full.
- empty, output, 1: count == 0.

Behaviour:
- Reset (async assert, sync-safe release):
  - wptr = rptr = 0 (n1+1 bits each, MSB is the wrap bit); rd_pend = 0; output buffer empty.
  - Outputs: m_valid = 0, s_ready = 1, full = 0, empty = 1, count = 0, ram_we = 0, ram_re = 0. m_data is don't-care while m_valid = 0.
- RAM contract: synchronous write; synchronous read with latency 1 (ram_rdata is valid in the cycle after an ram_re = 1 cycle). The controller samples ram_rdata only when rd_pend = 1.
- Write path:
  - full = (wptr[n1] != rptr[n1]) && (wptr[n1-1:0] == rptr[n1-1:0]); s_ready = !full.
  - ram_we = push, ram_wadr = wptr[n1-1:0], ram_wdata = s_data, all combinational. wptr increments on push; the wrap bit toggles at 2^n1.
- Read path:
  - ram_avail = (wptr != rptr), using registered pointers, so a word written this cycle is never read in the same cycle and no same-address collision occurs.
  - issue = ram_avail && (occ + rd_pend - pop < 2), where occ = output buffer entries (0..2).
  - ram_re = issue, ram_radr = rptr[n1-1:0]; rptr increments on issue. rd_pend <= issue.
- Output buffer (2-entry skid, in-order):
  - When rd_pend = 1, ram_rdata is written into the buffer.
  - m_valid = (occ != 0); m_data = oldest entry.
  - A pop and a load in the same cycle are both honoured.
- Throughput: with m_ready held 1 and the FIFO non-empty, one pop per cycle sustained.
- First-word latency from empty: push at cycle t; issue at t+1; m_valid at t+3.
- count:
  - Update: count_next = count + push - pop. Max 2^n1 + 2 = 34.
  - full refers to RAM occupancy only, so the block can hold up to 34 words.
- Simultaneous push and pop at full: the pop frees only an output-buffer slot, so s_ready stays 0 until a RAM issue advances rptr (next cycle).
- m_valid = 1 with m_ready = 0: m_data is held stable until popped.
- Reset mid-operation: all contents are discarded and the block returns to the reset state immediately. A pending RAM read result is ignored.

Optional Feature:
- Macro: DPRAM_FIFO_ALMOST_FULL_EN.
- Defined:
  - Adds parameter AF_LEVEL (default 28) and output almost_full (1 bit).
  - almost_full is registered, = (count_next >= AF_LEVEL); reset value 0.
- Undefined: neither the port nor the parameter exists; the rest of the behaviour is identical.

Decomposition:
- Package dpram_fifo_pkg:
  - Constants DPRAM_AW = 5, DPRAM_DW = 8, OBUF_DEPTH = 2.
  - Pointer typedef (AW+1 bits) and count typedef (AW+1 bits).
- Sub-module dpram_fifo_obuf: the 2-entry output skid buffer (load, pop, occ, m_valid, m_data).
- Pointers, full/empty logic and issue logic stay in dpram_fifo_ctrl.
- The bench instantiates DualPortRam alongside the controller.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n = 0 for 2 cycles, release.
  - Required: s_ready = 1, m_valid = 0, empty = 1, count = 0, ram_we = ram_re = 0.
- Single word:
  - Stimulus: push 8'h01 at cycle t, m_ready = 1.
  - Required: ram_we = 1 with ram_wadr = 0 at t; ram_re = 1 with ram_radr = 0 at t+1; m_valid = 1 with m_data = 8'h01 at t+3; empty = 1 after the pop.
- Fill to full:
  - Stimulus: m_ready = 0, push 8'h00..8'h21 (34 words).
  - Required: full = 1 and s_ready = 0 after the 34th accept; count = 34; the 35th s_valid is not accepted.
- Drain order across wrap:
  - Stimulus: continue from full, m_ready = 1.
  - Required: m_data sequence is 8'h00..8'h21, one per cycle with no bubbles; rptr wraps past address 31 → 0.
- Streaming with backpressure:
  - Stimulus: continuous push; m_ready toggles 1,0,1,0.
  - Required: no loss or duplication; m_data is held while m_ready = 0; count stays ≤ 34.
- Reset mid-stream:
  - Stimulus: assert rst_n = 0 while rd_pend = 1 and occ = 2.
  - Required: m_valid drops immediately; count = 0; the next push of 8'hAA is the first word out.
